pl_io_input_debounce: RTL and testbench

Input-side I/O conditioning stage for the pipelined CPU. It sits directly upstream of the data memory's memory-mapped input registers and produces the `in_port0`/`in_port1` words that loads with `addr[7]=1` return. Raw board switches and push-keys are synchronised into `clock`, debounced per bit, and key presses are captured as sticky events that software clears explicitly.

---
 rtl/pl_io_input_debounce_pkg.sv | 25 ++
 rtl/pl_debounce_bit.sv | 62 ++++++
 rtl/pl_io_input_debounce.sv | 98 +++++++++
 tb/tb_pl_io_input_debounce.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pl_io_input_debounce_pkg.sv
// -----------------------------------------------------------------------------
// pl_io_input_debounce_pkg
//   Shared constants for the input-side I/O conditioning stage: default sizes,
//   the field layout of the in_port1 word and the idle level of the raw keys.
// -----------------------------------------------------------------------------
package pl_io_input_debounce_pkg;

    // Default geometry: DE-class board with 10 slide switches and 4 keys,
    // 10 ms of stable input at 50 MHz.
    localparam int DEF_NSW             = 10;
    localparam int DEF_NKEY            = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    // in_port1 layout: debounced key levels in the low field, sticky press
    // events directly above them.
    localparam int KEY_DB_LSB = 0;

    function automatic int key_evt_lsb(input int nkey);
        return nkey;
    endfunction

    // Raw keys are active-low, so an untouched key reads 1.
    localparam logic KEY_IDLE = 1'b1;

endpackage : pl_io_input_debounce_pkg

// File: rtl/pl_debounce_bit.sv
// -----------------------------------------------------------------------------
// pl_debounce_bit
//   One-bit conditioner: 2-flop synchroniser followed by a saturating
//   stability counter. The stable value only follows the synchronised input
//   once the input has disagreed with it for DEBOUNCE_CYCLES consecutive
//   cycles; any shorter disagreement restarts the count.
//
// Ports
//   clock   : sampling clock
//   clrn    : asynchronous active-low reset
//   raw     : asynchronous input level (in its board polarity)
//   stable  : debounced level, registered, same polarity as raw
//   toggle  : high in the cycle whose closing edge flips 'stable'
// -----------------------------------------------------------------------------
module pl_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clock,
    input  logic clrn,
    input  logic raw,
    output logic stable,
    output logic toggle
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The stable value changes on this edge exactly when the input has been
    // different for the final counted cycle; the top uses this to set press
    // events on the same edge the debounced level moves.
    assign toggle = (sync2 != stable) && (cnt == CNT_MAX);

    // NOTE: state is updated with non-blocking assignments so sync1 -> sync2
    // really is two flops; blocking '=' here would collapse the chain.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            // Synchroniser and stable value start at the input's idle level
            // so reset never looks like an edge.
            sync1  <= RST_VAL;
            sync2  <= RST_VAL;
            stable <= RST_VAL;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : pl_debounce_bit

// File: rtl/pl_io_input_debounce.sv
// -----------------------------------------------------------------------------
// pl_io_input_debounce
//   Input conditioning for the memory-mapped input registers of the pipelined
//   CPU. Switches and keys are synchronised and debounced per bit; key presses
//   are latched as sticky events until software clears them.
//
// Ports
//   clock    : data-memory clock
//   clrn     : asynchronous active-low reset
//   sw_raw   : [NSW]  raw switch levels, active-high
//   key_raw  : [NKEY] raw key levels, active-low (0 = pressed)
//   evt_clr  : [NKEY] one-cycle clear pulse per sticky press event
//   in_port0 : {zeros, sw_db}
//   in_port1 : {zeros, key_evt, key_db}
// -----------------------------------------------------------------------------
module pl_io_input_debounce
    import pl_io_input_debounce_pkg::*;
#(
    parameter int NSW             = DEF_NSW,
    parameter int NKEY            = DEF_NKEY,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic            clock,
    input  logic            clrn,
    input  logic [NSW-1:0]  sw_raw,
    input  logic [NKEY-1:0] key_raw,
    input  logic [NKEY-1:0] evt_clr,
    output logic [31:0]     in_port0,
    output logic [31:0]     in_port1
);

    localparam int KEY_EVT_LSB = key_evt_lsb(NKEY);

    logic [NSW-1:0]  sw_db;
    // Switches carry no events, so their change strobes are deliberately left
    // without a consumer.
    logic [NSW-1:0]  sw_toggle_unused;

    logic [NKEY-1:0] key_level;   // debounced, board polarity (1 = released)
    logic [NKEY-1:0] key_toggle;
    logic [NKEY-1:0] key_db;      // debounced, 1 = pressed
    logic [NKEY-1:0] key_press;
    logic [NKEY-1:0] key_evt;

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        pl_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (1'b0)
        ) u_db (
            .clock  (clock),
            .clrn   (clrn),
            .raw    (sw_raw[i]),
            .stable (sw_db[i]),
            .toggle (sw_toggle_unused[i])
        );
    end

    // Keys are debounced in board polarity with an idle (released) reset
    // level; inverting the registered result is equivalent to inverting after
    // the synchroniser and keeps the sub-module polarity-agnostic.
    for (genvar i = 0; i < NKEY; i++) begin : g_key
        pl_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (KEY_IDLE)
        ) u_db (
            .clock  (clock),
            .clrn   (clrn),
            .raw    (key_raw[i]),
            .stable (key_level[i]),
            .toggle (key_toggle[i])
        );
    end

    assign key_db    = ~key_level;
    // A flip while currently released is a press; a flip while pressed is a
    // release and is ignored.
    assign key_press = key_toggle & ~key_db;

    // Clear first, then set: a press landing with its clear is never lost.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            key_evt <= '0;
        end else begin
            key_evt <= (key_evt & ~evt_clr) | key_press;
        end
    end

    // NOTE: every bit of a combinational output is given a default before the
    // field writes, so no latch is inferred for the unused upper bits.
    always_comb begin
        in_port0 = '0;
        in_port1 = '0;
        in_port0[NSW-1:0]                = sw_db;
        in_port1[KEY_DB_LSB  +: NKEY]    = key_db;
        in_port1[KEY_EVT_LSB +: NKEY]    = key_evt;
    end

endmodule : pl_io_input_debounce

// File: tb/tb_pl_io_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_pl_io_input_debounce
//   Self-checking bench for pl_io_input_debounce with a short debounce window.
//   A behavioural model tracks, per bit, the last DC synchronised samples and
//   flips the stable value when all of them disagree with it; the outputs are
//   compared against that model every cycle, and directed steps pin the model
//   with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_pl_io_input_debounce;

    localparam int NSW  = 10;
    localparam int NKEY = 4;
    localparam int DC   = 4;
    localparam int NB   = NSW + NKEY;

    typedef logic [NB-1:0] vec_t;   // [NSW-1:0] switches, upper bits keys (1 = pressed)

    logic            clock   = 1'b0;
    logic            clrn    = 1'b0;
    logic [NSW-1:0]  sw_raw  = '0;
    logic [NKEY-1:0] key_raw = '1;
    logic [NKEY-1:0] evt_clr = '0;
    logic [31:0]     in_port0;
    logic [31:0]     in_port1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pl_io_input_debounce #(
        .NSW             (NSW),
        .NKEY            (NKEY),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock    (clock),
        .clrn     (clrn),
        .sw_raw   (sw_raw),
        .key_raw  (key_raw),
        .evt_clr  (evt_clr),
        .in_port0 (in_port0),
        .in_port1 (in_port1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    vec_t            pipe[$];       // raw samples still travelling through the synchroniser
    vec_t            seen_hist[$];  // last DC synchronised samples
    vec_t            m_s   = '0;
    logic [NKEY-1:0] m_evt = '0;

    task automatic model_reset();
        pipe.delete();
        pipe.push_back('0);         // idle internal level: switches low, keys released
        pipe.push_back('0);
        seen_hist.delete();
        m_s   = '0;
        m_evt = '0;
    endtask

    always @(posedge clock or negedge clrn) begin : model
        vec_t            now;
        vec_t            seen;
        logic [NKEY-1:0] press;
        logic            all_diff;
        if (!clrn) begin
            model_reset();
        end else begin
            now  = {~key_raw, sw_raw};
            seen = pipe.pop_front();
            pipe.push_back(now);
            seen_hist.push_back(seen);
            if (seen_hist.size() > DC) void'(seen_hist.pop_front());
            press = '0;
            if (seen_hist.size() == DC) begin
                for (int b = 0; b < NB; b++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DC; k++)
                        if (seen_hist[k][b] == m_s[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (b >= NSW && !m_s[b]) press[b-NSW] = 1'b1;
                        m_s[b] = ~m_s[b];
                    end
                end
            end
            m_evt = (m_evt & ~evt_clr) | press;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin : compare
        logic [31:0] exp0;
        logic [31:0] exp1;
        #1;
        exp0 = 32'(m_s[NSW-1:0]);
        exp1 = 32'({m_evt, m_s[NB-1:NSW]});
        check("model_in_port0", in_port0, exp0);
        check("model_in_port1", in_port1, exp1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset with every input active
        sw_raw  = 10'h3FF;
        key_raw = 4'h0;
        clrn    = 1'b0;
        step(3);
        check("reset_in_port0", in_port0, 32'h0);
        check("reset_in_port1", in_port1, 32'h0);
        clrn = 1'b1;
        step(5);
        check("post_reset_edge5", in_port0, 32'h0);
        step(1);
        check("post_reset_edge6_p0", in_port0, 32'h3FF);
        check("post_reset_edge6_p1", in_port1, 32'hFF);

        // Return to idle, then clear all events
        sw_raw  = '0;
        key_raw = 4'hF;
        step(6);
        check("idle_p0", in_port0, 32'h0);
        check("idle_p1_events_held", in_port1, 32'hF0);
        evt_clr = 4'hF;
        step(1);
        evt_clr = '0;
        check("clear_all", in_port1, 32'h0);

        // Switch step
        sw_raw = 10'h2A5;
        step(5);
        check("sw_step_edge5", in_port0, 32'h0);
        step(1);
        check("sw_step_edge6", in_port0, 32'h2A5);
        sw_raw = '0;
        step(6);
        check("sw_step_release", in_port0, 32'h0);

        // Glitch rejection: 3 cycles high never qualifies
        sw_raw = 10'h001;
        step(3);
        sw_raw = '0;
        step(8);
        check("glitch_3cyc", in_port0, 32'h0);
        // 4 cycles and staying high qualifies
        sw_raw = 10'h001;
        step(6);
        check("pulse_4cyc", in_port0, 32'h1);
        sw_raw = '0;
        step(6);
        check("pulse_release", in_port0, 32'h0);

        // Key 2 press and release
        key_raw = 4'b1011;
        step(5);
        check("key2_edge5", in_port1, 32'h0);
        step(1);
        check("key2_press", in_port1, 32'h44);
        key_raw = 4'hF;
        step(6);
        check("key2_release", in_port1, 32'h40);
        evt_clr = 4'b0100;
        step(1);
        evt_clr = '0;
        check("key2_clear", in_port1, 32'h0);

        // Clear collision on key 1
        key_raw = 4'b1101;
        step(6);
        check("key1_first_press", in_port1, 32'h22);
        key_raw = 4'hF;
        step(6);
        check("key1_first_release", in_port1, 32'h20);
        key_raw = 4'b1101;
        step(5);
        evt_clr = 4'b0010;
        step(1);
        evt_clr = '0;
        check("collision_set_wins", in_port1, 32'h22);
        evt_clr = 4'b0010;
        step(1);
        evt_clr = '0;
        check("lone_clear_bit5", {31'b0, in_port1[5]}, 32'h0);
        check("lone_clear_word", in_port1, 32'h02);
        key_raw = 4'hF;
        step(6);
        check("key1_final_release", in_port1, 32'h0);

        // Reset mid-count
        sw_raw = 10'h008;
        step(3);
        clrn = 1'b0;
        step(1);
        check("midcount_reset", in_port0, 32'h0);
        clrn = 1'b1;
        step(5);
        check("midcount_edge5", in_port0, 32'h0);
        step(1);
        check("midcount_edge6", in_port0, 32'h8);
        sw_raw = '0;
        step(6);
        check("midcount_release", in_port0, 32'h0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pl_io_input_debounce
